// File: rtl/lcd_row_streamer_if.sv
// Bundle of the row-buffer read port, the start/busy/done handshake and the LCD SPI pins.
// master is the streamer; slave is the row writer, buffer and panel side.
interface lcd_row_streamer_if #(
    parameter int DATA_WDTH = 8,
    parameter int COL_BITS  = 9
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [COL_BITS-1:0]  addrb;
    logic [DATA_WDTH-1:0] doutb;
    logic                 lcd_cs_n;
    logic                 lcd_sclk;
    logic                 lcd_mosi;
    logic                 lcd_dc;

    modport master (
        input  start, doutb,
        output busy, done, addrb, lcd_cs_n, lcd_sclk, lcd_mosi, lcd_dc
    );

    modport slave (
        output start, doutb,
        input  busy, done, addrb, lcd_cs_n, lcd_sclk, lcd_mosi, lcd_dc
    );
endinterface

// File: rtl/lcd_row_streamer.sv
// Streams one row of the row buffer to the LCD over a write-only SPI link
// (mode 0, MSB first, DC high for pixel data), one buffer byte per address.
module lcd_row_streamer #(
    parameter int DATA_WDTH = 8,
    parameter int COL       = 480,
    parameter int COL_BITS  = 9,
    parameter int CLK_DIV   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_row_streamer_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_WDTH > 1) ? $clog2(DATA_WDTH) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_WDTH - 1);
    localparam logic [COL_BITS-1:0] ADDR_LAST = COL_BITS'(COL - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [COL_BITS-1:0]  addrb_q, addrb_d;
    logic [DATA_WDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 dc_q, dc_d;

    logic                 div_tc_s;
    logic                 sclk_fall_s;
    logic                 last_fall_s;

    // Divider terminal count and the falling SCLK edge that closes the last bit of a byte.
    always_comb begin
        div_tc_s    = (div_q == DIV_LAST);
        sclk_fall_s = (state_q == ST_SHIFT) && div_tc_s && sclk_q;
        last_fall_s = sclk_fall_s && (bit_cnt_q == BIT_LAST);
    end

    // State and datapath registers; reset also releases chip select at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addrb_q   <= {COL_BITS{1'b0}};
            shreg_q   <= {DATA_WDTH{1'b0}};
            bit_cnt_q <= {BIT_W{1'b0}};
            div_q     <= {DIV_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addrb_q   <= addrb_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (last_fall_s) begin
                    if (addrb_q == ADDR_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic; done is a one-cycle pulse, everything else holds unless changed.
    always_comb begin
        addrb_d   = addrb_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        dc_d      = dc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addrb_d = {COL_BITS{1'b0}};
                    cs_n_d  = 1'b0;
                    dc_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = busy_q;
                end
            end
            ST_FETCH: begin
                addrb_d = addrb_q;
            end
            ST_LOAD: begin
                shreg_d   = bus.doutb;
                mosi_d    = bus.doutb[DATA_WDTH-1];
                bit_cnt_d = {BIT_W{1'b0}};
                div_d     = {DIV_W{1'b0}};
            end
            ST_SHIFT: begin
                if (div_tc_s) begin
                    div_d  = {DIV_W{1'b0}};
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // The final fall leaves MOSI alone and advances the address unless the row is done.
                        if (bit_cnt_q == BIT_LAST) begin
                            if (addrb_q != ADDR_LAST) begin
                                addrb_d = addrb_q + COL_BITS'(1);
                            end else begin
                                addrb_d = addrb_q;
                            end
                        end else begin
                            shreg_d   = shreg_q << 1'b1;
                            mosi_d    = shreg_d[DATA_WDTH-1];
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        mosi_d = mosi_q;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_FINISH: begin
                cs_n_d = 1'b1;
                dc_d   = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = busy_q;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.addrb    = addrb_q;
    assign bus.lcd_cs_n = cs_n_q;
    assign bus.lcd_sclk = sclk_q;
    assign bus.lcd_mosi = mosi_q;
    assign bus.lcd_dc   = dc_q;
endmodule

// File: tb/tb_lcd_row_streamer.sv
// Scoreboard bench: a small instance (COL=4, CLK_DIV=1) and a default instance (COL=480, CLK_DIV=2)
// are checked against a cycle-count model of the row timing and a queue of expected bytes.
module tb_lcd_row_streamer;
    localparam int DW    = 8;
    localparam int CB    = 9;
    localparam int COL_S = 4;
    localparam int DIV_S = 1;
    localparam int COL_B = 480;
    localparam int DIV_B = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_row_streamer_if #(.DATA_WDTH(DW), .COL_BITS(CB)) if_s ();
    lcd_row_streamer_if #(.DATA_WDTH(DW), .COL_BITS(CB)) if_b ();

    lcd_row_streamer #(.DATA_WDTH(DW), .COL(COL_S), .COL_BITS(CB), .CLK_DIV(DIV_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s));
    lcd_row_streamer #(.DATA_WDTH(DW), .COL(COL_B), .COL_BITS(CB), .CLK_DIV(DIV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    logic [DW-1:0] ram_s [COL_S];
    logic [DW-1:0] ram_b [COL_B];

    // Row buffer read port: data one cycle after the address.
    always @(posedge clk) begin
        if_s.doutb <= ram_s[if_s.addrb[1:0]];
        if_b.doutb <= ram_b[int'(if_b.addrb) % COL_B];
    end

    int col_n [2] = '{COL_S, COL_B};
    int div_n [2] = '{DIV_S, DIV_B};
    int edges = 0;
    int vectors = 0;
    int miscompares = 0;

    bit have_row [2] = '{1'b0, 1'b0};
    int e0       [2] = '{0, 0};
    int done_at  [2] = '{0, 0};
    int free_at  [2] = '{0, 0};
    logic [DW-1:0] exp_byte_q [2][$];
    int            exp_done_q [2][$];

    logic        sclk_v [2], mosi_v [2], cs_v [2], dc_v [2], busy_v [2], done_v [2];
    logic [31:0] addr_v [2];
    logic        prev_sclk [2], prev_mosi [2];
    int          run_len [2], nbits [2], rises [2];
    logic [DW-1:0] acc [2];

    function automatic int byte_period(input int d);
        return 2 + 2 * DW * div_n[d];
    endfunction

    function automatic int row_len(input int d);
        return col_n[d] * byte_period(d) + 2;
    endfunction

    function automatic string tag(input int d);
        return (d == 0) ? "small" : "dflt";
    endfunction

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%s] @edge %0d: got %0h, expected %0h", name, tag(d), edges, act, exp);
        end
    endtask

    task automatic fail(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        miscompares++;
        $display("FAIL %s[%s] @edge %0d: got %0h, expected %0h", name, tag(d), edges, act, exp);
    endtask

    task automatic sample_outputs();
        sclk_v[0] = if_s.lcd_sclk; mosi_v[0] = if_s.lcd_mosi; cs_v[0] = if_s.lcd_cs_n;
        dc_v[0]   = if_s.lcd_dc;   busy_v[0] = if_s.busy;     done_v[0] = if_s.done;
        addr_v[0] = 32'(if_s.addrb);
        sclk_v[1] = if_b.lcd_sclk; mosi_v[1] = if_b.lcd_mosi; cs_v[1] = if_b.lcd_cs_n;
        dc_v[1]   = if_b.lcd_dc;   busy_v[1] = if_b.busy;     done_v[1] = if_b.done;
        addr_v[1] = 32'(if_b.addrb);
    endtask

    task automatic check_reset();
        sample_outputs();
        for (int d = 0; d < 2; d++) begin
            check(d, "rst_busy", 32'(busy_v[d]), 32'd0);
            check(d, "rst_done", 32'(done_v[d]), 32'd0);
            check(d, "rst_addrb", addr_v[d], 32'd0);
            check(d, "rst_cs_n", 32'(cs_v[d]), 32'd1);
            check(d, "rst_sclk", 32'(sclk_v[d]), 32'd0);
            check(d, "rst_mosi", 32'(mosi_v[d]), 32'd0);
            check(d, "rst_dc", 32'(dc_v[d]), 32'd0);
        end
    endtask

    // Reference model: a start sampled while the streamer is idle owes a full row of bytes
    // and a done pulse visible after edge e0+ROW-1 (the ROW-th cycle counting the sampling one).
    initial begin
        logic st [2];
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    have_row[d] = 1'b0;
                    free_at[d]  = 0;
                    exp_byte_q[d].delete();
                    exp_done_q[d].delete();
                end
            end else begin
                edges = edges + 1;
                st[0] = if_s.start;
                st[1] = if_b.start;
                for (int d = 0; d < 2; d++) begin
                    if (st[d] && edges >= free_at[d]) begin
                        have_row[d] = 1'b1;
                        e0[d]       = edges;
                        done_at[d]  = edges + row_len(d) - 1;
                        free_at[d]  = edges + row_len(d);
                        for (int i = 0; i < col_n[d]; i++) begin
                            if (d == 0) exp_byte_q[d].push_back(ram_s[i]);
                            else        exp_byte_q[d].push_back(ram_b[i]);
                        end
                        exp_done_q[d].push_back(done_at[d]);
                    end
                end
            end
        end
    end

    task automatic monitor_one(input int d);
        int bp;
        int k;
        int ph;
        int exp_addr;
        bit exp_busy;
        int want_at;
        logic [DW-1:0] want;
        bp       = byte_period(d);
        exp_busy = have_row[d] && edges >= e0[d] && edges < done_at[d];
        if (!have_row[d]) begin
            exp_addr = 0;
        end else begin
            k        = (edges - e0[d]) / bp;
            exp_addr = (k >= col_n[d]) ? col_n[d] - 1 : k;
        end
        check(d, "busy", 32'(busy_v[d]), 32'(exp_busy));
        check(d, "cs_n", 32'(cs_v[d]), 32'(!exp_busy));
        check(d, "dc", 32'(dc_v[d]), 32'(exp_busy));
        check(d, "addrb", addr_v[d], 32'(exp_addr));
        ph = exp_busy ? (edges - e0[d]) % bp : 0;
        if (!exp_busy || ph < 2) check(d, "sclk_idle", 32'(sclk_v[d]), 32'd0);

        if (sclk_v[d] && !prev_sclk[d]) begin
            check(d, "mosi_setup", 32'(mosi_v[d]), 32'(prev_mosi[d]));
            if (nbits[d] != 0) check(d, "sclk_low_time", 32'(run_len[d]), 32'(div_n[d]));
            acc[d]   = {acc[d][DW-2:0], mosi_v[d]};
            nbits[d] = nbits[d] + 1;
            rises[d] = rises[d] + 1;
            if (nbits[d] == DW) begin
                nbits[d] = 0;
                if (exp_byte_q[d].size() == 0) begin
                    fail(d, "byte_unexpected", 32'(acc[d]), 32'd0);
                end else begin
                    want = exp_byte_q[d].pop_front();
                    check(d, "byte", 32'(acc[d]), 32'(want));
                end
            end
        end else if (!sclk_v[d] && prev_sclk[d]) begin
            check(d, "sclk_high_time", 32'(run_len[d]), 32'(div_n[d]));
        end else if (sclk_v[d]) begin
            check(d, "mosi_hold", 32'(mosi_v[d]), 32'(prev_mosi[d]));
        end

        if (exp_done_q[d].size() != 0 && exp_done_q[d][0] < edges) begin
            want_at = exp_done_q[d].pop_front();
            fail(d, "done_missing", 32'(edges), 32'(want_at));
        end
        if (done_v[d]) begin
            if (exp_done_q[d].size() == 0) begin
                fail(d, "done_spurious", 32'(edges), 32'd0);
            end else begin
                want_at = exp_done_q[d].pop_front();
                check(d, "done_cycle", 32'(edges), 32'(want_at));
                check(d, "sclk_rises", 32'(rises[d]), 32'(DW * col_n[d]));
            end
            rises[d] = 0;
        end

        if (sclk_v[d] == prev_sclk[d]) run_len[d] = run_len[d] + 1;
        else                           run_len[d] = 1;
        prev_sclk[d] = sclk_v[d];
        prev_mosi[d] = mosi_v[d];
    endtask

    // Monitor: samples both instances mid-cycle and scores them against the model.
    initial begin
        forever begin
            @(negedge clk);
            sample_outputs();
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    prev_sclk[d] = 1'b0;
                    prev_mosi[d] = 1'b0;
                    run_len[d]   = 0;
                    nbits[d]     = 0;
                    rises[d]     = 0;
                    acc[d]       = '0;
                end else begin
                    monitor_one(d);
                end
            end
        end
    end

    task automatic set_start(input int d, input logic v);
        if (d == 0) if_s.start = v;
        else        if_b.start = v;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        while (exp_done_q[d].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail(d, "timeout", 32'(n), 32'(budget));
        @(negedge clk);
    endtask

    task automatic fill_small_random();
        for (int i = 0; i < COL_S; i++) ram_s[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        if_s.start = 1'b0;
        if_b.start = 1'b0;
        for (int i = 0; i < COL_S; i++) ram_s[i] = 8'h00;
        for (int i = 0; i < COL_B; i++) ram_b[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset();
        #2 rst_n = 1'b1;

        // Known row: A5 3C FF 00
        ram_s[0] = 8'hA5; ram_s[1] = 8'h3C; ram_s[2] = 8'hFF; ram_s[3] = 8'h00;
        pulse_start(0);
        wait_idle(0, 300);

        // A second start while busy is ignored
        fill_small_random();
        pulse_start(0);
        repeat (33) @(posedge clk);
        pulse_start(0);
        wait_idle(0, 300);

        // Random rows with random idle gaps
        for (int r = 0; r < 4; r++) begin
            fill_small_random();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            pulse_start(0);
            wait_idle(0, 300);
        end

        // Reset during bit 3 of byte 1, then a clean row
        fill_small_random();
        @(posedge clk); #1 if_s.start = 1'b1;
        @(posedge clk); #1 if_s.start = 1'b0;
        repeat (27) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk); #2 rst_n = 1'b1;
        fill_small_random();
        pulse_start(0);
        wait_idle(0, 300);

        // start held high: rows run back to back
        fill_small_random();
        @(posedge clk); #1 if_s.start = 1'b1;
        repeat (3 * row_len(0)) @(posedge clk);
        #1 if_s.start = 1'b0;
        wait_idle(0, 400);

        // Full-size row with default parameters
        for (int i = 0; i < COL_B; i++) ram_b[i] = 8'($urandom_range(0, 255));
        pulse_start(1);
        wait_idle(1, 17000);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
